// File: rtl/mem.sv
`default_nettype none
// ============================================================================
// Module   : mem
// Brief    : Memory-access pipeline stage; owns the EXE->MEM register, issues
//            loads/stores to a synchronous-read RAM, builds the MEM->WB bus.
// Revision : 1.0  initial release
// ============================================================================
module mem (
    input  logic         clk,
    input  logic         rst,
    input  logic         EXE_over,
    input  logic [153:0] EXE_MEM_bus,
    input  logic         cancel,
    input  logic         WB_allow_in,
    input  logic [31:0]  dm_rdata,
    output logic         MEM_allow_in,
    output logic         MEM_valid,
    output logic         MEM_over,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_wdata,
    output logic [117:0] MEM_WB_bus,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_pc
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_WAIT = 2'd1,
        S_LOAD_HOLD = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [153:0]   r_bus;
    logic           r_valid;
    logic           r_issued;
    logic [31:0]    r_rdata;

    logic           w_load_en;
    logic           w_inst_load;
    logic           w_inst_store;
    logic           w_ls_word;
    logic           w_lb_sign;
    logic [31:0]    w_store_data;
    logic [31:0]    w_exe_result;
    logic [31:0]    w_raw;
    logic [7:0]     w_byte;
    logic [31:0]    w_load_value;
    logic [31:0]    w_mem_result;
    logic [3:0]     w_wen;

    assign w_inst_load  = r_bus[153];
    assign w_inst_store = r_bus[152];
    assign w_ls_word    = r_bus[151];
    assign w_lb_sign    = r_bus[150];
    assign w_store_data = r_bus[149:118];
    assign w_exe_result = r_bus[117:86];

    assign MEM_allow_in = ~r_valid | (MEM_over & WB_allow_in);
    assign w_load_en    = EXE_over & MEM_allow_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus    <= '0;
            r_valid  <= 1'b0;
            r_issued <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_load_en) begin
                r_bus <= EXE_MEM_bus;
            end
            if (cancel) begin
                r_valid <= 1'b0;
            end else if (MEM_allow_in) begin
                r_valid <= EXE_over;
            end
            // r_issued marks that the first cycle (address/store issue) is done
            if (w_load_en) begin
                r_issued <= 1'b0;
            end else if (r_valid) begin
                r_issued <= 1'b1;
            end
            if (r_state == S_LOAD_WAIT) begin
                r_rdata <= dm_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_valid & w_inst_load & ~r_issued) begin
                    w_state_nxt = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: w_state_nxt = WB_allow_in ? S_IDLE : S_LOAD_HOLD;
            S_LOAD_HOLD: begin
                if (WB_allow_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
        if (cancel) begin
            w_state_nxt = S_IDLE;
        end
    end

    // RAM data is only live in LOAD_WAIT; a WB stall replays the captured copy
    assign w_raw = (r_state == S_LOAD_HOLD) ? r_rdata : dm_rdata;

    always_comb begin
        w_byte = w_raw[7:0];
        case (w_exe_result[1:0])
            2'd0:    w_byte = w_raw[7:0];
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            default: w_byte = w_raw[31:24];
        endcase
    end

    assign w_load_value = w_ls_word ? w_raw : {{24{w_lb_sign & w_byte[7]}}, w_byte};
    assign w_mem_result = w_inst_load ? w_load_value : w_exe_result;

    always_comb begin
        w_wen = 4'b0000;
        if (r_valid & w_inst_store & ~r_issued & ~cancel) begin
            w_wen = w_ls_word ? 4'b1111 : (4'b0001 << w_exe_result[1:0]);
        end
    end

    assign MEM_valid  = r_valid;
    assign MEM_over   = r_valid & (~w_inst_load | (r_state == S_LOAD_WAIT) |
                                   (r_state == S_LOAD_HOLD));
    assign dm_addr    = w_exe_result;
    assign dm_wen     = w_wen;
    assign dm_wdata   = w_ls_word ? w_store_data : {4{w_store_data[7:0]}};
    assign MEM_WB_bus = {r_bus[37], r_bus[36:32], w_mem_result, r_bus[85:54],
                         r_bus[53:38], r_bus[31:0]};
    assign MEM_wdest  = r_bus[36:32] & {5{r_valid}};
    assign MEM_pc     = r_bus[31:0];

endmodule
`default_nettype wire

// File: tb/tb_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem
// Brief    : Self-checking bench for mem: vector table, directed sequences and
//            randomized traffic against a transaction-level memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem;

    logic         clk;
    logic         rst;
    logic         EXE_over;
    logic [153:0] EXE_MEM_bus;
    logic         cancel;
    logic         WB_allow_in;
    logic [31:0]  dm_rdata;
    logic         MEM_allow_in;
    logic         MEM_valid;
    logic         MEM_over;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic [117:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;

    int checks   = 0;
    int failures = 0;

    mem u_dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .cancel       (cancel),
        .WB_allow_in  (WB_allow_in),
        .dm_rdata     (dm_rdata),
        .MEM_allow_in (MEM_allow_in),
        .MEM_valid    (MEM_valid),
        .MEM_over     (MEM_over),
        .dm_addr      (dm_addr),
        .dm_wen       (dm_wen),
        .dm_wdata     (dm_wdata),
        .MEM_WB_bus   (MEM_WB_bus),
        .MEM_wdest    (MEM_wdest),
        .MEM_pc       (MEM_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read, byte-lane writes, 64 words aliased by addr[7:2]
    logic        ram_mode;
    logic        ram_clr;
    logic [31:0] tb_rdata;
    logic [31:0] ram_q;
    logic [31:0] ram [0:63];

    function automatic logic [31:0] init_word(input int i);
        return (i + 1) * 32'h9E37_79B9;
    endfunction

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else begin
            for (int j = 0; j < 4; j++)
                if (dm_wen[j]) ram[dm_addr[7:2]][8*j +: 8] <= dm_wdata[8*j +: 8];
        end
        ram_q <= ram[dm_addr[7:2]];
    end

    assign dm_rdata = ram_mode ? ram_q : tb_rdata;

    function automatic logic [153:0] mk_bus(input logic [3:0] ctl, input logic [31:0] sdata,
                                            input logic [31:0] exe, input logic [31:0] lo,
                                            input logic [15:0] flg, input logic rfw,
                                            input logic [4:0] wd, input logic [31:0] pc);
        return {ctl, sdata, exe, lo, flg, rfw, wd, pc};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         ov;
        logic [153:0] bus;
        logic         cn;
        logic         wb;
        logic [31:0]  rd;
        logic         e_valid;
        logic         e_over;
        logic         e_allow;
        logic [3:0]   e_wen;
        logic [4:0]   e_wdest;
        logic         chk_wd;
        logic [31:0]  e_wdata;
        logic         chk_res;
        logic [31:0]  e_res;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ov, input logic [153:0] bus, input logic cn, input logic wb,
                       input logic [31:0] rd, input logic ev, input logic eo, input logic ea,
                       input logic [3:0] ew, input logic [4:0] ed, input logic cw,
                       input logic [31:0] ewd, input logic cr, input logic [31:0] er);
        vec_t v;
        v.ov = ov; v.bus = bus; v.cn = cn; v.wb = wb; v.rd = rd;
        v.e_valid = ev; v.e_over = eo; v.e_allow = ea; v.e_wen = ew; v.e_wdest = ed;
        v.chk_wd = cw; v.e_wdata = ewd; v.chk_res = cr; v.e_res = er;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // random traffic records
    typedef struct {
        logic [153:0] bus;
        logic [117:0] exp;
    } txn_t;
    txn_t txq[$];
    logic [31:0] ref_mem [0:63];

    logic [153:0] b_a, b_a2, b_sb, b_lbs, b_lbu, b_lw, b_lw2, b_lw3, b_sw;

    initial begin
        int tx, rx, cyc, nstores, nwrites;
        logic acc;

        rst = 1'b1; EXE_over = 1'b0; EXE_MEM_bus = '0; cancel = 1'b0;
        WB_allow_in = 1'b1; tb_rdata = '0; ram_mode = 1'b0; ram_clr = 1'b0;

        b_a   = mk_bus(4'b0000, 32'h0,         32'h1234_5678, 32'h0, 16'h0, 1'b1, 5'd5, 32'h100);
        b_a2  = mk_bus(4'b0000, 32'h0,         32'h0BAD_F00D, 32'h0, 16'h0, 1'b1, 5'd6, 32'h104);
        b_sb  = mk_bus(4'b0100, 32'h1234_56AB, 32'h0000_0103, 32'h0, 16'h0, 1'b0, 5'd0, 32'h108);
        b_lbs = mk_bus(4'b1001, 32'h0,         32'h0000_0102, 32'h0, 16'h0, 1'b1, 5'd7, 32'h10C);
        b_lbu = mk_bus(4'b1000, 32'h0,         32'h0000_0102, 32'h0, 16'h0, 1'b1, 5'd8, 32'h110);
        b_lw  = mk_bus(4'b1010, 32'h0,         32'h0000_0200, 32'h0, 16'h0, 1'b1, 5'd9, 32'h114);
        b_lw2 = mk_bus(4'b1010, 32'h0,         32'h0000_0204, 32'h0, 16'h0, 1'b1, 5'd10, 32'h118);
        b_lw3 = mk_bus(4'b1010, 32'h0,         32'h0000_0208, 32'h0, 16'h0, 1'b1, 5'd11, 32'h11C);
        b_sw  = mk_bus(4'b0110, 32'hCAFE_F00D, 32'h0000_0300, 32'h0, 16'h0, 1'b0, 5'd0, 32'h120);

        //   ov  bus    cn wb rdata          valid over allow wen    wdest cw wdata          cr res
        add(1, b_a,   0, 1, 32'h0,          0, 0, 1, 4'b0000, 5'd0,  0, 32'h0,          0, 32'h0);
        add(1, b_a2,  0, 1, 32'h0,          1, 1, 1, 4'b0000, 5'd5,  0, 32'h0,          1, 32'h1234_5678);
        add(1, b_sb,  0, 1, 32'h0,          1, 1, 1, 4'b0000, 5'd6,  0, 32'h0,          1, 32'h0BAD_F00D);
        add(0, b_sb,  0, 0, 32'h0,          1, 1, 0, 4'b1000, 5'd0,  1, 32'hABAB_ABAB,  1, 32'h0000_0103);
        add(0, b_sb,  0, 0, 32'h0,          1, 1, 0, 4'b0000, 5'd0,  0, 32'h0,          1, 32'h0000_0103);
        add(0, b_sb,  0, 0, 32'h0,          1, 1, 0, 4'b0000, 5'd0,  0, 32'h0,          1, 32'h0000_0103);
        add(1, b_lbs, 0, 1, 32'h0,          1, 1, 1, 4'b0000, 5'd0,  0, 32'h0,          1, 32'h0000_0103);
        add(1, b_lbu, 0, 1, 32'h0,          1, 0, 0, 4'b0000, 5'd7,  0, 32'h0,          0, 32'h0);
        add(1, b_lbu, 0, 1, 32'h80FF_0000,  1, 1, 1, 4'b0000, 5'd7,  0, 32'h0,          1, 32'hFFFF_FFFF);
        add(0, b_lbu, 0, 1, 32'h0,          1, 0, 0, 4'b0000, 5'd8,  0, 32'h0,          0, 32'h0);
        add(1, b_lw,  0, 1, 32'h80FF_0000,  1, 1, 1, 4'b0000, 5'd8,  0, 32'h0,          1, 32'h0000_00FF);
        add(0, b_lw,  0, 0, 32'h0,          1, 0, 0, 4'b0000, 5'd9,  0, 32'h0,          0, 32'h0);
        add(0, b_lw,  0, 0, 32'hDEAD_BEEF,  1, 1, 0, 4'b0000, 5'd9,  0, 32'h0,          1, 32'hDEAD_BEEF);
        add(0, b_lw,  0, 0, 32'h0,          1, 1, 0, 4'b0000, 5'd9,  0, 32'h0,          1, 32'hDEAD_BEEF);
        add(1, b_lw2, 0, 1, 32'h0,          1, 1, 1, 4'b0000, 5'd9,  0, 32'h0,          1, 32'hDEAD_BEEF);
        add(0, b_lw2, 0, 1, 32'h0,          1, 0, 0, 4'b0000, 5'd10, 0, 32'h0,          0, 32'h0);
        add(0, b_lw2, 1, 0, 32'h1111_2222,  1, 1, 0, 4'b0000, 5'd10, 0, 32'h0,          1, 32'h1111_2222);
        add(1, b_lw3, 0, 1, 32'h0,          0, 0, 1, 4'b0000, 5'd0,  0, 32'h0,          0, 32'h0);
        add(0, b_lw3, 0, 1, 32'h0,          1, 0, 0, 4'b0000, 5'd11, 0, 32'h0,          0, 32'h0);
        add(1, b_sw,  0, 1, 32'h1357_9BDF,  1, 1, 1, 4'b0000, 5'd11, 0, 32'h0,          1, 32'h1357_9BDF);
        add(0, b_sw,  1, 1, 32'h0,          1, 1, 1, 4'b0000, 5'd0,  1, 32'hCAFE_F00D,  1, 32'h0000_0300);
        add(0, b_sw,  0, 1, 32'h0,          0, 0, 1, 4'b0000, 5'd0,  0, 32'h0,          0, 32'h0);

        // reset: two cycles of rst
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_allow_in", {127'b0, MEM_allow_in}, 128'd1);
        chk("rst_valid",    {127'b0, MEM_valid},    128'd0);
        chk("rst_over",     {127'b0, MEM_over},     128'd0);
        chk("rst_wen",      {124'b0, dm_wen},       128'd0);
        chk("rst_wb_bus",   {10'b0, MEM_WB_bus},    128'd0);
        chk("rst_addr_pc",  {64'b0, dm_addr, MEM_pc}, 128'd0);
        chk("rst_wdata",    {96'b0, dm_wdata},      128'd0);
        chk("rst_wdest",    {123'b0, MEM_wdest},    128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            EXE_over = vecs[i].ov; EXE_MEM_bus = vecs[i].bus; cancel = vecs[i].cn;
            WB_allow_in = vecs[i].wb; tb_rdata = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {127'b0, MEM_valid},    {127'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_over", i),  {127'b0, MEM_over},     {127'b0, vecs[i].e_over});
            chk($sformatf("v%0d_allow", i), {127'b0, MEM_allow_in}, {127'b0, vecs[i].e_allow});
            chk($sformatf("v%0d_wen", i),   {124'b0, dm_wen},       {124'b0, vecs[i].e_wen});
            chk($sformatf("v%0d_wdest", i), {123'b0, MEM_wdest},    {123'b0, vecs[i].e_wdest});
            if (vecs[i].chk_wd)
                chk($sformatf("v%0d_wdata", i), {96'b0, dm_wdata}, {96'b0, vecs[i].e_wdata});
            if (vecs[i].chk_res)
                chk($sformatf("v%0d_result", i), {96'b0, MEM_WB_bus[111:80]}, {96'b0, vecs[i].e_res});
            next_cycle();
        end
        EXE_over = 1'b0; cancel = 1'b0;

        // rst in the middle of a stalled load
        EXE_over = 1'b1; EXE_MEM_bus = b_lw; WB_allow_in = 1'b0;
        next_cycle();
        EXE_over = 1'b0;
        next_cycle();
        tb_rdata = 32'h5555_AAAA;
        next_cycle();
        @(negedge clk);
        chk("hold_over", {127'b0, MEM_over}, 128'd1);
        chk("hold_res",  {96'b0, MEM_WB_bus[111:80]}, {96'b0, 32'h5555_AAAA});
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_mid_valid", {127'b0, MEM_valid},    128'd0);
        chk("rst_mid_allow", {127'b0, MEM_allow_in}, 128'd1);
        chk("rst_mid_bus",   {10'b0, MEM_WB_bus},    128'd0);
        ram_clr = 1'b1;
        next_cycle();
        ram_clr = 1'b0; rst = 1'b0; WB_allow_in = 1'b1; ram_mode = 1'b1;
        EXE_over = 1'b1; EXE_MEM_bus = b_lw2;
        next_cycle();
        EXE_over = 1'b0;
        @(negedge clk);
        chk("post_rst_load_c1_over", {127'b0, MEM_over}, 128'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_load_c2_over", {127'b0, MEM_over}, 128'd1);
        chk("post_rst_load_data", {96'b0, MEM_WB_bus[111:80]}, {96'b0, init_word(32'h204 >> 2 & 63)});
        next_cycle();

        // randomized traffic; expected results follow program order over ref_mem
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        nstores = 0;
        for (int n = 0; n < 400; n++) begin
            txn_t t;
            logic [3:0]  ctl;
            logic [31:0] sd, ex, lo, pc, res, w;
            logic [15:0] flg;
            logic [4:0]  wd;
            logic        rfw;
            logic [7:0]  b;
            int k, idx, lane;
            k = $urandom_range(0, 4);
            sd = $urandom; ex = $urandom; lo = $urandom; pc = $urandom;
            flg = 16'($urandom); wd = 5'($urandom); rfw = 1'($urandom);
            idx = int'(ex[7:2]); lane = int'(ex[1:0]);
            ctl = {2'b00, 2'($urandom)};
            res = ex;
            if (k == 2) begin
                ctl[2] = 1'b1;
                nstores++;
                if (ctl[1]) ref_mem[idx] = sd;
                else        ref_mem[idx][8*lane +: 8] = sd[7:0];
            end else if (k >= 3) begin
                ctl[3] = 1'b1;
                w = ref_mem[idx];
                b = 8'(w >> (8 * lane));
                if (ctl[1])      res = w;
                else if (ctl[0]) res = {{24{b[7]}}, b};
                else             res = {24'h0, b};
            end
            t.bus = mk_bus(ctl, sd, ex, lo, flg, rfw, wd, pc);
            t.exp = {rfw, wd, res, lo, flg, pc};
            txq.push_back(t);
        end

        tx = 0; rx = 0; cyc = 0; nwrites = 0;
        while (rx < txq.size() && cyc < 20000) begin
            EXE_over    = (tx < txq.size()) && ($urandom_range(0, 9) < 7);
            EXE_MEM_bus = (tx < txq.size()) ? txq[tx].bus : '0;
            WB_allow_in = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            acc = EXE_over && MEM_allow_in;
            if (MEM_over && WB_allow_in) begin
                chk($sformatf("rnd%0d_wb_bus", rx), {10'b0, MEM_WB_bus}, {10'b0, txq[rx].exp});
                rx++;
            end
            if (dm_wen != 4'b0000) nwrites++;
            next_cycle();
            if (acc) tx++;
            cyc++;
        end
        chk("rnd_all_retired", 128'(rx), 128'(txq.size()));
        chk("rnd_store_writes", 128'(nwrites), 128'(nstores));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem.md
# mem

Memory-access stage of the five-stage pipeline, the consumer of the EXE→MEM bus. It owns the EXE→MEM pipeline register and issues loads/stores to the synchronous-read data RAM. It sequences load completion with a small FSM and produces the 118-bit MEM→WB bus under valid/allow_in flow control.

## Interface
Parameters: none (bus widths fixed at 154 in, 118 out).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- EXE_over  in  1  EXE holds a finished instruction
- EXE_MEM_bus  in  154  [153:150] mem_control {inst_load,inst_store,ls_word,lb_sign}, [149:118] store_data, [117:86] exe_result, [85:54] lo_result, [53] hi_write, [52] lo_write, [51] mfhi, [50] mflo, [49] mtc0, [48] mfc0, [47:40] cp0r_addr, [39] syscall, [38] eret, [37] rf_wen, [36:32] rf_wdest, [31:0] pc
- cancel  in  1  exception/eret flush; kills the MEM-resident instruction
- WB_allow_in  in  1  WB accepts this cycle
- dm_rdata  in  32  RAM read data, valid the cycle after address presented
- MEM_allow_in  out  1  MEM can accept from EXE
- MEM_valid  out  1  MEM holds a live instruction
- MEM_over  out  1  MEM result ready for WB
- dm_addr  out  32  RAM byte address
- dm_wen  out  4  RAM byte write enables
- dm_wdata  out  32  RAM write data
- MEM_WB_bus  out  118  [117] rf_wen, [116:112] rf_wdest, [111:80] mem_result, [79:48] lo_result, [47] hi_write, [46] lo_write, [45] mfhi, [44] mflo, [43] mtc0, [42] mfc0, [41:34] cp0r_addr, [33] syscall, [32] eret, [31:0] pc
- MEM_wdest  out  5  rf_wdest & {5{MEM_valid}} for hazard detection
- MEM_pc  out  32  pc of resident instruction (display)

## Operation
- Bus register bus_r loads EXE_MEM_bus when EXE_over & MEM_allow_in; otherwise holds.
- MEM_valid: rst→0; cancel→0; else if MEM_allow_in → EXE_over; else holds.
- MEM_allow_in = ~MEM_valid | (MEM_over & WB_allow_in).
- issued_r: cleared on each bus_r load; set after the first MEM_valid cycle. Marks the first cycle of an instruction.
- FSM states IDLE, LOAD_WAIT, LOAD_HOLD:
  - IDLE→LOAD_WAIT when MEM_valid & inst_load & ~issued_r & ~cancel.
  - In LOAD_WAIT, dm_rdata is valid and is captured into rdata_r. The FSM goes to IDLE if WB_allow_in, else to LOAD_HOLD.
  - LOAD_HOLD→IDLE when WB_allow_in.
  - cancel in any state→IDLE.
- MEM_over = MEM_valid & (~inst_load | state==LOAD_WAIT | state==LOAD_HOLD).
- dm_addr = exe_result.
- Stores:
  - dm_wen nonzero only when MEM_valid & inst_store & ~issued_r & ~cancel, so each store writes exactly once even if stalled.
  - Word (ls_word=1): dm_wen=4'b1111, dm_wdata=store_data.
  - Byte: dm_wen=4'b0001<<addr[1:0], dm_wdata={4{store_data[7:0]}}.
- Loads:
  - Raw data is dm_rdata in LOAD_WAIT and rdata_r in LOAD_HOLD.
  - Word: raw. Byte: select raw[8*addr[1:0]+:8], then sign-extend if lb_sign, else zero-extend.
  - Word-address misalignment is not checked; addr[1:0] is ignored for words.
- mem_result = inst_load ? load_value : exe_result. All other MEM_WB_bus fields pass through from bus_r.

## Timing
- Reset: bus_r=0, MEM_valid=0, state IDLE, issued_r=0. Hence MEM_over=0, MEM_allow_in=1, dm_wen=0, dm_addr=0, dm_wdata=0, MEM_WB_bus=0, MEM_wdest=0, MEM_pc=0.
- Non-load: MEM_over in the first valid cycle, giving 1-cycle latency and full throughput.
- Load: address in cycle 1, MEM_over in cycle 2 (LOAD_WAIT). This gives a 2-cycle minimum with one bubble per load.
- WB stall: MEM_over held. bus_r, dm_addr and the load value are stable until the handoff (MEM_over & WB_allow_in).
- Simultaneous handoff and new EXE_over: the new instruction loads in the same edge, with no gap cycle.
- cancel: dm_wen is suppressed in the same cycle. MEM_valid=0 and state=IDLE on the next edge. A cancel during LOAD_WAIT or LOAD_HOLD drops the load.
- rst mid-load or mid-stall returns the block to reset values on the next edge.

## Test plan
- Reset: hold rst 2 cycles → MEM_allow_in=1, MEM_valid=0, dm_wen=0, MEM_WB_bus=0.
- ALU op: exe_result=0x1234_5678, rf_wen=1, rf_wdest=5, WB_allow_in=1 → next cycle MEM_over=1, MEM_WB_bus[111:80]=0x1234_5678, MEM_wdest=5. Back-to-back ALU ops see no bubbles.
- Store byte: addr=0x103, store_data=0xAB → one cycle with dm_wen=4'b1000 and dm_wdata=0xABAB_ABAB. With WB_allow_in=0 held 3 cycles, dm_wen stays 0 after the first cycle.
- Load byte: addr=0x102, dm_rdata=0x80FF_0000:
  - lb_sign=1 gives mem_result=0xFFFF_FFFF.
  - lb_sign=0 gives 0x0000_00FF.
  - MEM_over appears in the 2nd cycle.
- Load word with WB stall: dm_rdata=0xDEAD_BEEF in LOAD_WAIT, then changed to 0 during LOAD_HOLD → mem_result stays 0xDEAD_BEEF until WB_allow_in=1.
- cancel in LOAD_WAIT, and separately in the first store cycle → MEM_valid=0 next cycle, no MEM_over, dm_wen=0.
